// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute/write-back stage placed after the register file.
// Single-cycle ALU ops commit one cycle after accept. MUL runs an 8-step
// shift-add sequence and stalls upstream until it completes.
// Handshake: an op transfers on a rising edge where InValid and InReady are
// both high. InReady is high only in IDLE and outside reset. An op offered
// while InReady is low is ignored, so upstream must keep holding it.
module alu_exec_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int OP_W   = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [OP_W-1:0]   Opcode,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [DATA_W-1:0] DataA,
    input  logic [DATA_W-1:0] DataB,
    output logic              WR,
    output logic [ADDR_W-1:0] DA,
    output logic [DATA_W-1:0] WrData,
    output logic [3:0]        Flags,
    output logic              Busy
);

    localparam int MSB   = DATA_W - 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [OP_W-1:0] OP_ADD = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB = 4'd2;
    localparam logic [OP_W-1:0] OP_AND = 4'd3;
    localparam logic [OP_W-1:0] OP_OR  = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR = 4'd5;
    localparam logic [OP_W-1:0] OP_NOT = 4'd6;
    localparam logic [OP_W-1:0] OP_SHL = 4'd7;
    localparam logic [OP_W-1:0] OP_SHR = 4'd8;
    localparam logic [OP_W-1:0] OP_INC = 4'd9;
    localparam logic [OP_W-1:0] OP_DEC = 4'd10;
    localparam logic [OP_W-1:0] OP_MOV = 4'd11;
    localparam logic [OP_W-1:0] OP_MUL = 4'd12;
    localparam logic [OP_W-1:0] OP_CMP = 4'd13;

    localparam logic [DATA_W:0] ONE_EXT = 1;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t              r_state;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_da;
    logic [DATA_W-1:0]   r_wrdata;
    logic [3:0]          r_flags;
    logic                r_busy;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_mul_a;
    logic [DATA_W-1:0]   r_mul_b;
    logic [2*DATA_W-1:0] r_prod;
    logic [ADDR_W-1:0]   r_mul_dst;

    logic                w_accept;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_res;
    logic                w_c;
    logic                w_v;
    logic                w_writes;
    logic                w_upd;
    logic [2*DATA_W-1:0] w_prod_next;

    assign InReady  = (r_state == S_IDLE) & ~Reset;
    assign w_accept = InValid & InReady;

    assign WR     = r_wr;
    assign DA     = r_da;
    assign WrData = r_wrdata;
    assign Flags  = r_flags;
    assign Busy   = r_busy;

    // Single-cycle ALU: result, carry/borrow, overflow and write/flag-update intent.
    always_comb begin
        w_sum    = '0;
        w_res    = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_writes = 1'b0;
        w_upd    = 1'b0;
        case (Opcode)
            OP_ADD: begin
                w_sum    = {1'b0, DataA} + {1'b0, DataB};
                w_res    = w_sum[DATA_W-1:0];
                w_c      = w_sum[DATA_W];
                w_v      = (DataA[MSB] == DataB[MSB]) && (w_res[MSB] != DataA[MSB]);
                w_writes = 1'b1;
                w_upd    = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                // Bit DATA_W of the extended difference is the borrow (A < B).
                w_sum    = {1'b0, DataA} - {1'b0, DataB};
                w_res    = w_sum[DATA_W-1:0];
                w_c      = w_sum[DATA_W];
                w_v      = (DataA[MSB] != DataB[MSB]) && (w_res[MSB] != DataA[MSB]);
                w_writes = (Opcode == OP_SUB);
                w_upd    = 1'b1;
            end
            OP_AND: begin
                w_res    = DataA & DataB;
                w_writes = 1'b1;
                w_upd    = 1'b1;
            end
            OP_OR: begin
                w_res    = DataA | DataB;
                w_writes = 1'b1;
                w_upd    = 1'b1;
            end
            OP_XOR: begin
                w_res    = DataA ^ DataB;
                w_writes = 1'b1;
                w_upd    = 1'b1;
            end
            OP_NOT: begin
                w_res    = ~DataA;
                w_writes = 1'b1;
                w_upd    = 1'b1;
            end
            OP_SHL: begin
                w_res    = {DataA[DATA_W-2:0], 1'b0};
                w_c      = DataA[MSB];
                w_writes = 1'b1;
                w_upd    = 1'b1;
            end
            OP_SHR: begin
                w_res    = {1'b0, DataA[DATA_W-1:1]};
                w_c      = DataA[0];
                w_writes = 1'b1;
                w_upd    = 1'b1;
            end
            OP_INC: begin
                w_sum    = {1'b0, DataA} + ONE_EXT;
                w_res    = w_sum[DATA_W-1:0];
                w_c      = w_sum[DATA_W];
                w_v      = ~DataA[MSB] & w_res[MSB];
                w_writes = 1'b1;
                w_upd    = 1'b1;
            end
            OP_DEC: begin
                w_sum    = {1'b0, DataA} - ONE_EXT;
                w_res    = w_sum[DATA_W-1:0];
                w_c      = w_sum[DATA_W];
                w_v      = DataA[MSB] & ~w_res[MSB];
                w_writes = 1'b1;
                w_upd    = 1'b1;
            end
            OP_MOV: begin
                w_res    = DataB;
                w_writes = 1'b1;
                w_upd    = 1'b1;
            end
            default: begin
                // NOP, reserved codes; MUL is handled by the sequencer.
                w_res = '0;
            end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    always_comb begin
        w_prod_next = r_prod + (r_mul_b[0] ? r_mul_a : '0);
    end

    // Stage FSM and registered write-port / flag outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_wr      <= 1'b0;
            r_da      <= '0;
            r_wrdata  <= '0;
            r_flags   <= '0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_prod    <= '0;
            r_mul_dst <= '0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (Opcode == OP_MUL) begin
                            r_state   <= S_MUL;
                            r_busy    <= 1'b1;
                            r_cnt     <= '0;
                            r_mul_a   <= {{DATA_W{1'b0}}, DataA};
                            r_mul_b   <= DataB;
                            r_prod    <= '0;
                            r_mul_dst <= DstAddr;
                        end else begin
                            if (w_writes) begin
                                r_wr     <= (DstAddr != '0);
                                r_da     <= DstAddr;
                                r_wrdata <= w_res;
                            end
                            if (w_upd) begin
                                r_flags <= {(w_res == '0), w_res[MSB], w_c, w_v};
                            end
                        end
                    end
                end
                S_MUL: begin
                    r_prod  <= w_prod_next;
                    r_mul_a <= r_mul_a << 1;
                    r_mul_b <= r_mul_b >> 1;
                    r_cnt   <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_cnt    <= '0;
                        r_wr     <= (r_mul_dst != '0);
                        r_da     <= r_mul_dst;
                        r_wrdata <= w_prod_next[DATA_W-1:0];
                        r_flags  <= {(w_prod_next[DATA_W-1:0] == '0),
                                     w_prod_next[MSB],
                                     (w_prod_next[2*DATA_W-1:DATA_W] != '0),
                                     1'b0};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: randomized and directed stimulus, arithmetic reference
// model, and a write-port scoreboard popped by an independent monitor.
module tb_alu_exec_stage;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int OP_W   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              wr;
    logic [ADDR_W-1:0] da;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        flags;
    logic              busy;

    int tests = 0;
    int fails = 0;

    // Expected write-port events: {addr, data, flags}
    logic [14:0] exp_q[$];
    logic [14:0] mon_e;
    logic [3:0]  model_flags;
    int          wr_streak;
    int          wr_streak_max;

    alu_exec_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
        .Clk     (clk),
        .Reset   (reset),
        .InValid (in_valid),
        .InReady (in_ready),
        .Opcode  (opcode),
        .DstAddr (dst_addr),
        .DataA   (data_a),
        .DataB   (data_b),
        .WR      (wr),
        .DA      (da),
        .WrData  (wr_data),
        .Flags   (flags),
        .Busy    (busy)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic void model(input int op, input int a, input int b,
                                  output bit wr_op, output bit upd,
                                  output int res, output logic [3:0] fl);
        int sa, sb, full, sv;
        bit c, v;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c = 0; v = 0; res = 0;
        wr_op = (op >= 1 && op <= 12);
        upd   = (op >= 1 && op <= 13);
        case (op)
            1: begin full = a + b; res = full & 255; c = full > 255;
                     sv = sa + sb; v = (sv > 127) || (sv < -128); end
            2, 13: begin full = a - b; res = full & 255; c = a < b;
                     sv = sa - sb; v = (sv > 127) || (sv < -128); end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = 255 - a;
            7: begin res = (a * 2) & 255; c = a >= 128; end
            8: begin res = a / 2; c = (a % 2) == 1; end
            9: begin res = (a + 1) & 255; c = a == 255; v = (sa + 1) > 127; end
            10: begin res = (a - 1) & 255; c = a == 0; v = (sa - 1) < -128; end
            11: res = b;
            12: begin full = a * b; res = full % 256; c = full > 255; end
            default: res = 0;
        endcase
        fl = {res == 0, res >= 128, c, v};
    endfunction

    // driver: wait for InReady, present the op for one edge, record expectations
    task automatic issue_op(input int op, input int dst, input int a, input int b);
        bit w, u;
        int res;
        logic [3:0] fl;
        logic [ADDR_W-1:0] d;
        logic [DATA_W-1:0] r8;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1;
        opcode   = OP_W'(op);
        dst_addr = ADDR_W'(dst);
        data_a   = DATA_W'(a);
        data_b   = DATA_W'(b);
        model(op, a, b, w, u, res, fl);
        if (u) model_flags = fl;
        d  = ADDR_W'(dst);
        r8 = DATA_W'(res);
        if (w && dst != 0) exp_q.push_back({d, r8, fl});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic settle_check_flags(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        check(name, 32'(flags), 32'(model_flags));
    endtask

    // monitor: pop one expectation per WR pulse
    always @(negedge clk) begin
        if (!reset && wr) begin
            wr_streak = wr_streak + 1;
            if (wr_streak > wr_streak_max) wr_streak_max = wr_streak;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_da", 32'(da), 32'(mon_e[14:12]));
                check("wr_data", 32'(wr_data), 32'(mon_e[11:4]));
                check("wr_flags", 32'(flags), 32'(mon_e[3:0]));
            end
        end else begin
            wr_streak = 0;
        end
    end

    initial begin
        int guard;
        wr_streak     = 0;
        wr_streak_max = 0;
        model_flags   = 4'h0;
        reset    = 1'b1;
        in_valid = 1'b0;
        opcode   = '0;
        dst_addr = '0;
        data_a   = '0;
        data_b   = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_da", 32'(da), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        // ADD overflow into sign bit
        issue_op(1, 1, 8'h7F, 8'h01);
        @(negedge clk);
        check("add_wr", 32'(wr), 32'd1);
        check("add_data", 32'(wr_data), 32'h80);
        check("add_flags", 32'(flags), 32'b0101);

        // SUB with borrow, then CMP with same operands
        issue_op(2, 2, 8'h03, 8'h05);
        @(negedge clk);
        check("sub_data", 32'(wr_data), 32'hFE);
        check("sub_flags", 32'(flags), 32'b0110);
        issue_op(13, 2, 8'h03, 8'h05);
        @(negedge clk);
        check("cmp_wr", 32'(wr), 32'd0);
        check("cmp_flags", 32'(flags), 32'b0110);

        // MUL latency and stall
        issue_op(12, 3, 8'h0D, 8'h0B);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mul_in_ready", 32'(in_ready), 32'd0);
            check("mul_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("mul_wr_lat", 32'(wr), 32'd1);
        check("mul_data", 32'(wr_data), 32'h8F);
        check("mul_flags", 32'(flags), 32'b0100);
        check("mul_done_busy", 32'(busy), 32'd0);
        issue_op(12, 4, 8'h20, 8'h10);
        settle_check_flags("mul_ovf_flags");
        check("mul_ovf_direct", 32'(flags), 32'b1010);

        // back-to-back ADD, XOR, INC(0xFF)
        repeat (2) @(negedge clk);
        wr_streak_max = 0;
        issue_op(1, 1, 8'h10, 8'h20);
        issue_op(5, 2, 8'hF0, 8'h3C);
        issue_op(9, 3, 8'hFF, 8'h00);
        @(negedge clk);
        check("b2b_inc_data", 32'(wr_data), 32'h00);
        check("b2b_inc_flags", 32'(flags), 32'b1010);
        @(negedge clk);
        check("b2b_streak", 32'(wr_streak_max), 32'd3);

        // DstAddr 0: flags update without WR; NOP / reserved leave flags alone
        issue_op(2, 0, 8'h00, 8'h01);
        @(negedge clk);
        check("r0_wr", 32'(wr), 32'd0);
        check("r0_flags", 32'(flags), 32'b0110);
        issue_op(0, 5, 8'h00, 8'h00);
        @(negedge clk);
        check("nop_wr", 32'(wr), 32'd0);
        check("nop_flags", 32'(flags), 32'b0110);
        issue_op(14, 6, 8'h00, 8'h00);
        @(negedge clk);
        check("op14_flags", 32'(flags), 32'b0110);
        issue_op(3, 0, 8'hF0, 8'h0F);
        @(negedge clk);
        check("and_r0_flags", 32'(flags), 32'b1000);
        issue_op(10, 7, 8'h80, 8'h00);
        settle_check_flags("dec_flags");

        // reset in the middle of a multiply
        issue_op(12, 5, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        model_flags = 4'h0;
        @(posedge clk);
        #1;
        check("mrst_wr", 32'(wr), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_flags", 32'(flags), 32'd0);
        check("mrst_data", 32'(wr_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("mrst_in_ready", 32'(in_ready), 32'd1);
        repeat (10) @(negedge clk);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            issue_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            if ($urandom_range(0, 4) == 0) settle_check_flags("rand_flags");
        end
        settle_check_flags("rand_flags_end");

        // drain
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
